pc_stack: RTL and testbench

PC_STACK -- requirements
Module: pc_stack

---
 rtl/pc_stack_pkg.sv | 37 +++
 rtl/pc_lifo.sv | 53 +++++
 rtl/pc_stack.sv | 89 ++++++++
 tb/tb_pc_stack.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pc_stack_pkg.sv
// Shared CPU package: PC stack defaults and operation encoding.
package pc_stack_pkg;

  localparam int PC_WIDTH = 16;
  localparam int PC_DEPTH = 8;

  // Listed lowest to highest priority.
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_REL,
    OP_LOAD,
    OP_CALL,
    OP_RET
  } pc_op_e;

  function automatic pc_op_e pc_decode(
    input logic ret,
    input logic call,
    input logic load,
    input logic rel,
    input logic inc
  );
    pc_op_e op;
    op = OP_HOLD;
    priority case (1'b1)
      ret:     op = OP_RET;
      call:    op = OP_CALL;
      load:    op = OP_LOAD;
      rel:     op = OP_REL;
      inc:     op = OP_INC;
      default: op = OP_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/pc_lifo.sv
// Return-address LIFO; reset clears the depth count only, not storage.
module pc_lifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int DW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DW-1:0]    r_depth;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_top_idx;
  logic             w_push;
  logic             w_pop;

  assign full      = (r_depth == DW'(DEPTH));
  assign empty     = (r_depth == '0);
  assign depth     = r_depth;
  assign w_wr_idx  = r_depth[AW-1:0];
  assign w_top_idx = w_wr_idx - AW'(1);
  assign dout      = r_mem[w_top_idx];

  // Pop wins if both are requested.
  assign w_pop  = pop && !empty;
  assign w_push = push && !pop && !full;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_depth <= '0;
    end else if (w_pop) begin
      r_depth <= r_depth - DW'(1);
    end else if (w_push) begin
      r_depth <= r_depth + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[w_wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_stack.sv
// Program counter with priority-decoded jump/branch/call/return and
// a return-address stack with sticky overflow/underflow flags.
module pc_stack
  import pc_stack_pkg::*;
#(
  parameter int              WIDTH        = PC_WIDTH,
  parameter int              DEPTH        = PC_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  localparam int DW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             rel,
  input  logic             inc,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] out,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
);

  logic [WIDTH-1:0] r_out;
  logic             r_ovf;
  logic             r_unf;
  pc_op_e           w_op;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_rel;
  logic [WIDTH-1:0] w_top;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_op   = pc_decode(ret, call, load, rel, inc);
  assign w_inc  = r_out + WIDTH'(1);
  assign w_rel  = r_out + in;
  assign w_push = !reset && (w_op == OP_CALL) && !w_full;
  assign w_pop  = !reset && (w_op == OP_RET) && !w_empty;

  pc_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_inc),
    .dout  (w_top),
    .depth (depth),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= RESET_VECTOR;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      unique case (w_op)
        OP_RET: begin
          if (w_empty) r_unf <= 1'b1;
          else         r_out <= w_top;
        end
        OP_CALL: begin
          if (w_full) r_ovf <= 1'b1;
          else        r_out <= in;
        end
        OP_LOAD: r_out <= in;
        OP_REL:  r_out <= w_rel;
        OP_INC:  r_out <= w_inc;
        default: r_out <= r_out;
      endcase
    end
  end

  assign out   = r_out;
  assign full  = w_full;
  assign empty = w_empty;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack (WIDTH=16, DEPTH=4).
module tb_pc_stack;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic        rel;
  logic        inc;
  logic        call;
  logic        ret;
  logic [15:0] out;
  logic [2:0]  depth;
  logic        full;
  logic        empty;
  logic        ovf;
  logic        unf;

  int n_checks = 0;
  int n_fails  = 0;

  pc_stack #(
    .WIDTH        (16),
    .DEPTH        (4),
    .RESET_VECTOR (16'h0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .load  (load),
    .rel   (rel),
    .inc   (inc),
    .call  (call),
    .ret   (ret),
    .out   (out),
    .depth (depth),
    .full  (full),
    .empty (empty),
    .ovf   (ovf),
    .unf   (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ops = {reset, ret, call, load, rel, inc}
  task automatic step(input logic [5:0] ops, input logic [15:0] d);
    {reset, ret, call, load, rel, inc} = ops;
    in = d;
    @(posedge clk);
    #1;
    {reset, ret, call, load, rel, inc} = '0;
    in = '0;
  endtask

  localparam logic [5:0] RST  = 6'b100000;
  localparam logic [5:0] RET  = 6'b010000;
  localparam logic [5:0] CALL = 6'b001000;
  localparam logic [5:0] LD   = 6'b000100;
  localparam logic [5:0] REL  = 6'b000010;
  localparam logic [5:0] INC  = 6'b000001;
  localparam logic [5:0] NOP  = 6'b000000;

  initial begin
    {reset, ret, call, load, rel, inc} = '0;
    in = '0;
    @(negedge clk);
    step(RST, 16'h0);
    step(RST, 16'h0);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_unf", 32'(unf), 32'd0);

    step(LD, 16'h002A);
    chk("load", 32'(out), 32'h002A);
    step(INC, 16'h0);
    chk("inc1", 32'(out), 32'h002B);
    step(INC, 16'h0);
    chk("inc2", 32'(out), 32'h002C);
    step(NOP, 16'h1234);
    chk("hold", 32'(out), 32'h002C);

    step(LD, 16'h0010);
    step(REL, 16'hFFFC);
    chk("rel_neg", 32'(out), 32'h000C);
    step(LD, 16'hFFFF);
    step(INC, 16'h0);
    chk("inc_wrap", 32'(out), 32'h0000);
    step(REL, 16'hFFFF);
    chk("rel_wrap", 32'(out), 32'hFFFF);

    step(LD, 16'h0100);
    step(CALL, 16'h0200);
    chk("call_out", 32'(out), 32'h0200);
    chk("call_depth", 32'(depth), 32'd1);
    chk("call_empty", 32'(empty), 32'd0);
    step(RET, 16'h0);
    chk("ret_out", 32'(out), 32'h0101);
    chk("ret_depth", 32'(depth), 32'd0);
    chk("ret_empty", 32'(empty), 32'd1);

    step(LD, 16'h1000);
    for (int i = 0; i < 4; i++) step(CALL, 16'h2000 + 16'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_depth", 32'(depth), 32'd4);
    chk("fill_out", 32'(out), 32'h2003);
    chk("fill_ovf", 32'(ovf), 32'd0);
    step(CALL, 16'h0300);
    chk("ovf_out", 32'(out), 32'h2003);
    chk("ovf_depth", 32'(depth), 32'd4);
    chk("ovf_flag", 32'(ovf), 32'd1);
    step(RET, 16'h0);
    chk("pop3", 32'(out), 32'h2003);
    chk("pop3_full", 32'(full), 32'd0);
    step(RET, 16'h0);
    chk("pop2", 32'(out), 32'h2002);
    step(RET, 16'h0);
    chk("pop1", 32'(out), 32'h2001);
    step(RET, 16'h0);
    chk("pop0", 32'(out), 32'h1001);
    chk("pop0_empty", 32'(empty), 32'd1);
    chk("pop0_unf", 32'(unf), 32'd0);
    step(RET, 16'h0);
    chk("unf_out", 32'(out), 32'h1001);
    chk("unf_flag", 32'(unf), 32'd1);
    chk("unf_depth", 32'(depth), 32'd0);
    step(LD, 16'h0005);
    step(CALL, 16'h0006);
    chk("sticky_ovf", 32'(ovf), 32'd1);
    chk("sticky_unf", 32'(unf), 32'd1);
    step(RST, 16'h0);
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_unf", 32'(unf), 32'd0);
    chk("clr_empty", 32'(empty), 32'd1);

    step(LD, 16'h0054);
    step(CALL, 16'h0777);
    chk("pre_cr_depth", 32'(depth), 32'd1);
    step(CALL | RET, 16'h0999);
    chk("cr_out", 32'(out), 32'h0055);
    chk("cr_depth", 32'(depth), 32'd0);
    chk("cr_ovf", 32'(ovf), 32'd0);
    step(LD | INC, 16'h0064);
    chk("ldinc_out", 32'(out), 32'h0064);
    step(LD | REL, 16'h0070);
    chk("ldrel_out", 32'(out), 32'h0070);
    step(CALL, 16'h0800);
    step(RST | CALL, 16'h0123);
    chk("rc_out", 32'(out), 32'h0000);
    chk("rc_depth", 32'(depth), 32'd0);
    chk("rc_ovf", 32'(ovf), 32'd0);
    chk("rc_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
